// File: rtl/vio_switch_n.sv
// vio_switch_n: N-region vFPGA I/O stream switch.
// Sources 0..N_ID-1 are the host sinks (fixed route to dtu_src[i]);
// sources N_ID..2*N_ID-1 are the DTU sinks, steered by their route word.
// Outputs 0..N_ID-1 are host_src, outputs N_ID..2*N_ID-1 are dtu_src.
//
// Source FSM:
//   state      | meaning
//   SRC_IDLE   | waiting for the first beat of a packet
//   SRC_ROUTED | destination and route word latched, beats flow via a grant
//   SRC_DROP   | undecodable packet, beats consumed and discarded
//
// Output FSM:
//   state      | meaning
//   OUT_FREE   | round-robin arbitration over requesting sources
//   OUT_LOCKED | connected to the granted source until its tlast is accepted
module vio_switch_n #(
    parameter int N_ID       = 3,
    parameter int DATA_BITS  = 512,
    parameter int PID_BITS   = 6,
    parameter int ROUTE_BITS = 14,
    parameter int DEST_LSB   = 3,
    parameter int DEST_BITS  = 3
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_ID-1:0]               host_sink_tvalid,
    output logic [N_ID-1:0]               host_sink_tready,
    input  logic [N_ID-1:0]               host_sink_tlast,
    input  logic [N_ID*DATA_BITS-1:0]     host_sink_tdata,
    input  logic [N_ID*DATA_BITS/8-1:0]   host_sink_tkeep,
    output logic [N_ID-1:0]               host_src_tvalid,
    input  logic [N_ID-1:0]               host_src_tready,
    output logic [N_ID-1:0]               host_src_tlast,
    output logic [N_ID*DATA_BITS-1:0]     host_src_tdata,
    output logic [N_ID*DATA_BITS/8-1:0]   host_src_tkeep,
    input  logic [N_ID-1:0]               dtu_sink_tvalid,
    output logic [N_ID-1:0]               dtu_sink_tready,
    input  logic [N_ID-1:0]               dtu_sink_tlast,
    input  logic [N_ID*DATA_BITS-1:0]     dtu_sink_tdata,
    input  logic [N_ID*DATA_BITS/8-1:0]   dtu_sink_tkeep,
    input  logic [N_ID*PID_BITS-1:0]      dtu_sink_tid,
    output logic [N_ID-1:0]               dtu_src_tvalid,
    input  logic [N_ID-1:0]               dtu_src_tready,
    output logic [N_ID-1:0]               dtu_src_tlast,
    output logic [N_ID*DATA_BITS-1:0]     dtu_src_tdata,
    output logic [N_ID*DATA_BITS/8-1:0]   dtu_src_tkeep,
    output logic [N_ID*PID_BITS-1:0]      dtu_src_tid,
    input  logic [N_ID*ROUTE_BITS-1:0]    route_in,
    output logic [N_ID*ROUTE_BITS-1:0]    route_out,
    output logic [N_ID-1:0]               decode_err,
    output logic [15:0]                   drop_cnt
);
    localparam int NS = 2 * N_ID;
    localparam int SW = $clog2(NS);
    localparam int KB = DATA_BITS / 8;

    typedef enum logic [1:0] {SRC_IDLE, SRC_ROUTED, SRC_DROP} src_state_e;
    typedef enum logic {OUT_FREE, OUT_LOCKED} out_state_e;

    logic [NS-1:0]         s_tvalid, s_tlast, s_tready;
    logic [DATA_BITS-1:0]  s_tdata [NS];
    logic [KB-1:0]         s_tkeep [NS];
    logic [PID_BITS-1:0]   s_tid [NS];
    logic [NS-1:0]         dec_ok;
    logic [SW-1:0]         dec_tgt [NS];
    logic [ROUTE_BITS-1:0] dec_route [NS];

    src_state_e            src_state_q [NS], src_state_d [NS];
    logic [SW-1:0]         tgt_q [NS], tgt_d [NS];
    logic [ROUTE_BITS-1:0] route_q [NS], route_d [NS];
    logic [NS-1:0]         req;
    logic [SW-1:0]         req_tgt [NS];
    logic [NS-1:0]         drop_start;

    out_state_e            out_state_q [NS], out_state_d [NS];
    logic [SW-1:0]         grant_q [NS], grant_d [NS];
    logic [SW-1:0]         ptr_q [NS], ptr_d [NS];
    logic [NS-1:0]         o_tvalid, o_tready, o_tlast;
    logic [DATA_BITS-1:0]  o_tdata [NS];
    logic [KB-1:0]         o_tkeep [NS];

    logic [15:0]           drop_cnt_q, drop_cnt_d;

    // Gather all sources into uniform arrays and decode their destinations.
    always_comb begin
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '{default: '0};
        s_tkeep   = '{default: '0};
        s_tid     = '{default: '0};
        dec_ok    = '0;
        dec_tgt   = '{default: '0};
        dec_route = '{default: '0};
        for (int i = 0; i < N_ID; i++) begin
            s_tvalid[i]       = host_sink_tvalid[i];
            s_tlast[i]        = host_sink_tlast[i];
            s_tdata[i]        = host_sink_tdata[i*DATA_BITS +: DATA_BITS];
            s_tkeep[i]        = host_sink_tkeep[i*KB +: KB];
            dec_ok[i]         = 1'b1;
            dec_tgt[i]        = SW'(N_ID + i);
            s_tvalid[N_ID+i]  = dtu_sink_tvalid[i];
            s_tlast[N_ID+i]   = dtu_sink_tlast[i];
            s_tdata[N_ID+i]   = dtu_sink_tdata[i*DATA_BITS +: DATA_BITS];
            s_tkeep[N_ID+i]   = dtu_sink_tkeep[i*KB +: KB];
            s_tid[N_ID+i]     = dtu_sink_tid[i*PID_BITS +: PID_BITS];
            dec_route[N_ID+i] = route_in[i*ROUTE_BITS +: ROUTE_BITS];
            dec_ok[N_ID+i]    = int'(route_in[i*ROUTE_BITS+DEST_LSB +: DEST_BITS]) < NS;
            dec_tgt[N_ID+i]   = SW'(route_in[i*ROUTE_BITS+DEST_LSB +: DEST_BITS]);
        end
    end

    // Requests include IDLE sources with a decodable first beat so that the
    // grant lands on the same edge that latches the route.
    always_comb begin
        req     = '0;
        req_tgt = '{default: '0};
        for (int s = 0; s < NS; s++) begin
            if (src_state_q[s] == SRC_ROUTED) begin
                req[s]     = 1'b1;
                req_tgt[s] = tgt_q[s];
            end else if (src_state_q[s] == SRC_IDLE) begin
                req[s]     = s_tvalid[s] & dec_ok[s];
                req_tgt[s] = dec_tgt[s];
            end
        end
    end

    // Output mux: a locked output follows its granted source combinationally.
    always_comb begin
        o_tvalid = '0;
        o_tlast  = '0;
        o_tdata  = '{default: '0};
        o_tkeep  = '{default: '0};
        for (int m = 0; m < N_ID; m++) begin
            o_tready[m]      = host_src_tready[m];
            o_tready[N_ID+m] = dtu_src_tready[m];
        end
        for (int m = 0; m < NS; m++) begin
            if (out_state_q[m] == OUT_LOCKED) begin
                o_tvalid[m] = s_tvalid[grant_q[m]];
                o_tlast[m]  = s_tlast[grant_q[m]];
                o_tdata[m]  = s_tdata[grant_q[m]];
                o_tkeep[m]  = s_tkeep[grant_q[m]];
            end
        end
    end

    // Source tready: always-ready while dropping, otherwise the granted output's tready.
    always_comb begin
        s_tready = '0;
        for (int s = 0; s < NS; s++) begin
            if (src_state_q[s] == SRC_DROP) begin
                s_tready[s] = 1'b1;
            end
            for (int m = 0; m < NS; m++) begin
                if (out_state_q[m] == OUT_LOCKED && grant_q[m] == SW'(s)) begin
                    s_tready[s] = o_tready[m];
                end
            end
        end
    end

    // Source FSM next state; route word and destination captured at start of packet.
    always_comb begin
        src_state_d = src_state_q;
        tgt_d       = tgt_q;
        route_d     = route_q;
        drop_start  = '0;
        for (int s = 0; s < NS; s++) begin
            case (src_state_q[s])
                SRC_IDLE: begin
                    if (s_tvalid[s]) begin
                        if (dec_ok[s]) begin
                            src_state_d[s] = SRC_ROUTED;
                            tgt_d[s]       = dec_tgt[s];
                            route_d[s]     = dec_route[s];
                        end else begin
                            src_state_d[s] = SRC_DROP;
                            drop_start[s]  = 1'b1;
                        end
                    end
                end
                SRC_ROUTED, SRC_DROP: begin
                    if (s_tvalid[s] && s_tready[s] && s_tlast[s]) begin
                        src_state_d[s] = SRC_IDLE;
                    end
                end
                default: src_state_d[s] = SRC_IDLE;
            endcase
        end
    end

    // Source FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int s = 0; s < NS; s++) begin
                src_state_q[s] <= SRC_IDLE;
                tgt_q[s]       <= '0;
                route_q[s]     <= '0;
            end
        end else begin
            src_state_q <= src_state_d;
            tgt_q       <= tgt_d;
            route_q     <= route_d;
        end
    end

    // Output FSM next state with round-robin search starting at the pointer.
    always_comb begin
        logic          found;
        logic [SW-1:0] pick;
        logic [SW-1:0] cand;
        int            idx;
        found       = 1'b0;
        pick        = '0;
        cand        = '0;
        idx         = 0;
        out_state_d = out_state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        for (int m = 0; m < NS; m++) begin
            found = 1'b0;
            pick  = '0;
            case (out_state_q[m])
                OUT_FREE: begin
                    for (int k = 0; k < NS; k++) begin
                        idx = int'(ptr_q[m]) + k;
                        if (idx >= NS) begin
                            idx = idx - NS;
                        end
                        cand = SW'(idx);
                        if (!found && req[cand] && req_tgt[cand] == SW'(m)) begin
                            found = 1'b1;
                            pick  = cand;
                        end
                    end
                    if (found) begin
                        out_state_d[m] = OUT_LOCKED;
                        grant_d[m]     = pick;
                        ptr_d[m]       = (pick == SW'(NS - 1)) ? '0 : pick + 1'b1;
                    end
                end
                OUT_LOCKED: begin
                    if (o_tvalid[m] && o_tready[m] && o_tlast[m]) begin
                        out_state_d[m] = OUT_FREE;
                    end
                end
                default: out_state_d[m] = OUT_FREE;
            endcase
        end
    end

    // Output FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int m = 0; m < NS; m++) begin
                out_state_q[m] <= OUT_FREE;
                grant_q[m]     <= '0;
                ptr_q[m]       <= '0;
            end
        end else begin
            out_state_q <= out_state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
        end
    end

    // Saturating drop counter; several sources may start a drop in one cycle.
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, drop_cnt_q};
        for (int s = 0; s < NS; s++) begin
            if (drop_start[s]) begin
                sum = sum + 17'd1;
            end
        end
        drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Drop counter register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Scatter outputs back onto the flattened ports.
    always_comb begin
        host_sink_tready = s_tready[N_ID-1:0];
        dtu_sink_tready  = s_tready[NS-1:N_ID];
        host_src_tvalid  = '0;
        host_src_tlast   = '0;
        host_src_tdata   = '0;
        host_src_tkeep   = '0;
        dtu_src_tvalid   = '0;
        dtu_src_tlast    = '0;
        dtu_src_tdata    = '0;
        dtu_src_tkeep    = '0;
        dtu_src_tid      = '0;
        route_out        = '0;
        decode_err       = '0;
        for (int m = 0; m < N_ID; m++) begin
            host_src_tvalid[m]                     = o_tvalid[m];
            host_src_tlast[m]                      = o_tlast[m];
            host_src_tdata[m*DATA_BITS +: DATA_BITS] = o_tdata[m];
            host_src_tkeep[m*KB +: KB]             = o_tkeep[m];
            dtu_src_tvalid[m]                      = o_tvalid[N_ID+m];
            dtu_src_tlast[m]                       = o_tlast[N_ID+m];
            dtu_src_tdata[m*DATA_BITS +: DATA_BITS] = o_tdata[N_ID+m];
            dtu_src_tkeep[m*KB +: KB]              = o_tkeep[N_ID+m];
            if (out_state_q[N_ID+m] == OUT_LOCKED) begin
                dtu_src_tid[m*PID_BITS +: PID_BITS] = s_tid[grant_q[N_ID+m]];
                if (grant_q[N_ID+m] >= SW'(N_ID)) begin
                    route_out[m*ROUTE_BITS +: ROUTE_BITS] = route_q[grant_q[N_ID+m]];
                end
            end
            // Suppressed while in reset so the error line is quiet with the FSMs held.
            decode_err[m] = drop_start[N_ID+m] & ~areset;
        end
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: doc/vio_switch_n.md
Name: vio_switch_n

Overview:
- Parametrised N-region vFPGA I/O stream switch between the shell host streams and the per-region DTU user-logic streams.
- Host traffic into region i is delivered to that region's DTU output.
- Each DTU output packet is steered by its region's route word to any host or DTU output.
- Successor to the fixed 3-region switch. Adds:
  - packet-atomic round-robin arbitration per output;
  - route capture at start of packet;
  - drop of undecodable packets, with error pulses and a counter.

Parameters:
- N_ID, 3, number of vFPGA regions (1..8).
- DATA_BITS, 512, tdata width; tkeep is DATA_BITS/8.
- PID_BITS, 6, tid width.
- ROUTE_BITS, 14, route word width.
- DEST_LSB, 3, LSB of the destination field in the route word.
- DEST_BITS, 3, destination field width; requires 2^DEST_BITS >= 2*N_ID.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- host_sink_tvalid/tready/tlast  in/out/in  N_ID  shell-to-switch streams, one per region
- host_sink_tdata  in  N_ID*DATA_BITS
- host_sink_tkeep  in  N_ID*DATA_BITS/8
- host_src_tvalid/tready/tlast  out/in/out  N_ID  switch-to-shell streams
- host_src_tdata  out  N_ID*DATA_BITS
- host_src_tkeep  out  N_ID*DATA_BITS/8
- dtu_sink_tvalid/tready/tlast  in/out/in  N_ID  user-logic-to-switch streams
- dtu_sink_tdata  in  N_ID*DATA_BITS
- dtu_sink_tkeep  in  N_ID*DATA_BITS/8
- dtu_sink_tid  in  N_ID*PID_BITS
- dtu_src_tvalid/tready/tlast  out/in/out  N_ID  switch-to-user-logic streams
- dtu_src_tdata  out  N_ID*DATA_BITS
- dtu_src_tkeep  out  N_ID*DATA_BITS/8
- dtu_src_tid  out  N_ID*PID_BITS
- route_in  in  N_ID*ROUTE_BITS  per-region route word, applied to dtu_sink[i]
- route_out  out  N_ID*ROUTE_BITS  route word of the packet currently granted on dtu_src[m]
- decode_err  out  N_ID  1-cycle pulse per dtu_sink on an undecodable packet
- drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Sources are 2*N_ID:
  - host_sink[i] is source i, and always targets dtu_src[i]; its tid is forced to 0.
  - dtu_sink[i] is source N_ID+i.
- Decode of dtu_sink[i]: d = route_in[i][DEST_LSB +: DEST_BITS].
  - d < N_ID → host_src[d].
  - N_ID <= d < 2*N_ID → dtu_src[d-N_ID].
  - Otherwise → invalid.
- Per-source FSM, states IDLE, ROUTED, DROP:
  - IDLE→ROUTED on tvalid with a valid decode. The destination and the route_in word are latched in the same cycle.
  - IDLE→DROP on tvalid with an invalid decode. decode_err[i] pulses in that cycle.
  - ROUTED and DROP return to IDLE on an accepted beat with tlast.
  - Changes to route_in while in ROUTED/DROP have no effect until the next packet.
- DROP: tready=1; all beats are consumed and discarded. drop_cnt increments once per packet, on the first beat, and saturates at 0xFFFF.
- Per-output FSM, states FREE, LOCKED:
  - FREE: round-robin arbitration over ROUTED sources targeting this output. Priority starts at the index after the last grant. Grant is registered; LOCKED is entered on the next edge.
  - LOCKED: the output is connected combinationally to the granted source (tvalid, tdata, tkeep, tlast, tid). tready returns to that source; all other sources see tready=0.
  - LOCKED→FREE on an accepted beat with tlast.
- Latency: 1 cycle from first tvalid in IDLE to first output tvalid; 0 cycles per beat thereafter. Back-to-back packets from different sources cost 1 idle cycle per grant.
- route_out[m] holds the latched route word of the granted DTU-sourced packet. It is 0 when FREE or when the granted source is a host sink.
- Simultaneous tlast-accept and a new request: the grant frees this cycle and re-arbitrates next cycle; no beat is lost or duplicated.
- Single-beat packets (tvalid & tlast on the first beat) are supported in every state.
- Reset, including mid-packet:
  - all FSMs return to IDLE/FREE and round-robin pointers to 0;
  - all tvalid/tready outputs, route_out, decode_err and drop_cnt are 0;
  - tdata/tkeep/tlast/tid outputs are 0;
  - partial packets are abandoned.

Test Plan:
- Host sink to DTU: N_ID=3; host_sink[1] sends a 4-beat packet with tdata=0xA0..0xA3 → dtu_src[1] delivers 4 beats with tid=0, first beat 1 cycle after tvalid, route_out[1]=0.
- Routed DTU to host: route_in[0]=14'h0010 (d=2) → dtu_sink[0] 3-beat packet appears on host_src[2] with tid preserved. Changing route_in[0] to d=4 after beat 1 does not redirect beats 2-3.
- Contention: dtu_sink[0] (d=3) and dtu_sink[2] (d=3) request dtu_src[0] in the same cycle → packets are delivered whole, in order 0 then 2 with no interleaving; the next round grants 2 first.
- Decode error: route_in[1] d=7 → decode_err[1] pulses once, the 5-beat packet is fully consumed, no output tvalid, drop_cnt=1. A following valid packet routes normally.
- Backpressure: host_src[0].tready toggles 1/0 every cycle during an 8-beat packet → all 8 beats arrive in order, and the source sees tready mirror the sink's tready exactly.
- Reset mid-packet: assert areset on beat 2 of 6 → all outputs 0 immediately. After deassert, a new packet from the same source is granted with 1-cycle latency.
